conv1d_maxpool_seq: RTL and testbench

//  Parametrised single-channel 1-D convolution with fused max-pool, bias, fixed-point rescale and optional ReLU.

---
 rtl/conv1d_maxpool_seq.sv | 188 ++++++++++++++++++
 tb/tb_conv1d_maxpool_seq.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_maxpool_seq.sv
// Single-channel 1-D convolution (sequential MAC) with bias, rescale, optional ReLU and fused max-pool.
// Latency: o_stb_out rises K+1 edges after the edge that accepts the last sample of a pool group.
// Backpressure: no input is accepted during MAC/POST/OUT, so a stalled consumer stalls the input stream.
//
// Ports:
//   clk, RST          clock (rising edge), asynchronous active-high reset
//   i_EN_w, i_EN_c    start weight load / start-continue compute run (sampled in IDLE; i_EN_c also at OUT exit)
//   o_busy            high whenever the block is not idle
//   i_data, i_stb_in  weight/bias/sample word and its strobe; o_ack_in is the ready
//   o_data, o_stb_out pooled result and its strobe, held until i_ack_out
module conv1d_maxpool_seq #(
  parameter int DW     = 16,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int POOL   = 2,
  parameter int FRAC   = 0,
  parameter int RELU   = 0
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          i_EN_w,
  input  logic          i_EN_c,
  output logic          o_busy,
  input  logic [DW-1:0] i_data,
  input  logic          i_stb_in,
  output logic          o_ack_in,
  output logic [DW-1:0] o_data,
  output logic          o_stb_out,
  input  logic          i_ack_out
);

  // Accumulator is wide enough that K full-scale products can never overflow.
  localparam int ACCW = 2*DW + $clog2(K);
  localparam int CW   = $clog2(K+1);
  localparam int TW   = $clog2(K);
  localparam int PW   = $clog2(POOL+1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_FILL = 3'd2;
  localparam logic [2:0] S_MAC  = 3'd3;
  localparam logic [2:0] S_POST = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;

  localparam logic signed [ACCW:0] SAT_MAX = {{(ACCW+2-DW){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW:0] SAT_MIN = {{(ACCW+2-DW){1'b1}}, {(DW-1){1'b0}}};

  logic [2:0]             state;
  logic signed [DW-1:0]   w [K];
  logic signed [DW-1:0]   x [K];
  logic signed [DW-1:0]   bias;
  logic [CW-1:0]          cnt;      // word count in LOAD, sample count in FILL
  logic [TW-1:0]          tap;
  logic [PW-1:0]          pos;
  logic                   primed;   // window already holds a full position in this run
  logic signed [ACCW-1:0] acc;
  logic signed [DW-1:0]   best;

  logic                   xfer;
  logic [CW-1:0]          need;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] shifted;
  logic signed [ACCW:0]   sum;
  logic signed [DW-1:0]   y_sat;
  logic signed [DW-1:0]   y;
  logic signed [DW-1:0]   best_nxt;

  assign o_busy   = (state != S_IDLE);
  assign o_ack_in = (state == S_LOAD) || (state == S_FILL);
  assign xfer     = i_stb_in & o_ack_in;

  // First position of a run needs a full window; later ones only STRIDE fresh samples.
  assign need     = primed ? CW'(STRIDE) : CW'(K);

  assign prod     = w[tap] * x[tap];
  assign prod_ext = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
  assign shifted  = acc >>> FRAC;
  // One extra bit so the bias add itself cannot wrap before saturation.
  assign sum      = {shifted[ACCW-1], shifted} + {{(ACCW+1-DW){bias[DW-1]}}, bias};

  always_comb begin
    y_sat = sum[DW-1:0];
    if (sum > SAT_MAX) begin
      y_sat = {1'b0, {(DW-1){1'b1}}};
    end else if (sum < SAT_MIN) begin
      y_sat = {1'b1, {(DW-1){1'b0}}};
    end
    y = y_sat;
    if (RELU != 0 && y_sat[DW-1]) begin
      y = '0;
    end
    best_nxt = (pos == '0 || y > best) ? y : best;
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      for (int i = 0; i < K; i++) begin
        w[i] <= '0;
        x[i] <= '0;
      end
      bias      <= '0;
      cnt       <= '0;
      tap       <= '0;
      pos       <= '0;
      primed    <= 1'b0;
      acc       <= '0;
      best      <= '0;
      o_data    <= '0;
      o_stb_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_EN_w && !i_EN_c) begin
            state <= S_LOAD;
            cnt   <= '0;
          end else if (!i_EN_w && i_EN_c) begin
            state  <= S_FILL;
            cnt    <= '0;
            pos    <= '0;
            primed <= 1'b0;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            if (cnt == CW'(K)) begin
              bias  <= i_data;
              state <= S_IDLE;
            end else begin
              // Shift in from the top so the first word ends up in w[0].
              for (int i = 0; i < K-1; i++) begin
                w[i] <= w[i+1];
              end
              w[K-1] <= i_data;
              cnt    <= cnt + 1'b1;
            end
          end
        end
        S_FILL: begin
          if (xfer) begin
            for (int i = 0; i < K-1; i++) begin
              x[i] <= x[i+1];
            end
            x[K-1] <= i_data;
            if ((cnt + 1'b1) == need) begin
              state  <= S_MAC;
              cnt    <= '0;
              acc    <= '0;
              tap    <= '0;
              primed <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          if (tap == TW'(K-1)) begin
            state <= S_POST;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        S_POST: begin
          best <= best_nxt;
          if ((pos + 1'b1) == PW'(POOL)) begin
            o_data    <= best_nxt;
            o_stb_out <= 1'b1;
            pos       <= '0;
            state     <= S_OUT;
          end else begin
            pos   <= pos + 1'b1;
            state <= S_FILL;
          end
        end
        S_OUT: begin
          if (i_ack_out) begin
            o_stb_out <= 1'b0;
            state     <= i_EN_c ? S_FILL : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_maxpool_seq.sv
module tb_conv1d_maxpool_seq;

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      data;
  logic [3:0]       en_w, en_c, stb, ack_out;
  wire  [3:0]       busy, ack_in, ostb;
  wire  [3:0][15:0] odata;

  int total = 0;
  int bad   = 0;

  // Unit configurations: 0 basic, 1 ReLU, 2 stride, 3 wider kernel with rescale
  int uK[4] = '{3, 3, 3, 4};
  int uS[4] = '{1, 1, 2, 3};
  int uP[4] = '{2, 2, 1, 3};
  int uF[4] = '{0, 0, 0, 3};
  int uR[4] = '{0, 1, 0, 0};

  int wgt[4][4];
  int bia[4];
  int smp[$];
  int exp_q[$];
  int outq[$];
  int latq[$];
  int bp_bad;
  int bp_cnt;
  bit to_flag;

  always #5 clk = ~clk;

  conv1d_maxpool_seq #(.DW(16), .K(3), .STRIDE(1), .POOL(2), .FRAC(0), .RELU(0)) u_a (
    .clk(clk), .RST(rst), .i_EN_w(en_w[0]), .i_EN_c(en_c[0]), .o_busy(busy[0]),
    .i_data(data), .i_stb_in(stb[0]), .o_ack_in(ack_in[0]),
    .o_data(odata[0]), .o_stb_out(ostb[0]), .i_ack_out(ack_out[0]));
  conv1d_maxpool_seq #(.DW(16), .K(3), .STRIDE(1), .POOL(2), .FRAC(0), .RELU(1)) u_b (
    .clk(clk), .RST(rst), .i_EN_w(en_w[1]), .i_EN_c(en_c[1]), .o_busy(busy[1]),
    .i_data(data), .i_stb_in(stb[1]), .o_ack_in(ack_in[1]),
    .o_data(odata[1]), .o_stb_out(ostb[1]), .i_ack_out(ack_out[1]));
  conv1d_maxpool_seq #(.DW(16), .K(3), .STRIDE(2), .POOL(1), .FRAC(0), .RELU(0)) u_c (
    .clk(clk), .RST(rst), .i_EN_w(en_w[2]), .i_EN_c(en_c[2]), .o_busy(busy[2]),
    .i_data(data), .i_stb_in(stb[2]), .o_ack_in(ack_in[2]),
    .o_data(odata[2]), .o_stb_out(ostb[2]), .i_ack_out(ack_out[2]));
  conv1d_maxpool_seq #(.DW(16), .K(4), .STRIDE(3), .POOL(3), .FRAC(3), .RELU(0)) u_d (
    .clk(clk), .RST(rst), .i_EN_w(en_w[3]), .i_EN_c(en_c[3]), .o_busy(busy[3]),
    .i_data(data), .i_stb_in(stb[3]), .o_ack_in(ack_in[3]),
    .o_data(odata[3]), .o_stb_out(ostb[3]), .i_ack_out(ack_out[3]));

  // Reference: convolve the whole sample list at once, then reduce groups of P by max.
  task automatic model(input int u);
    int k = uK[u];
    int s = uS[u];
    int p = uP[u];
    int npos;
    longint a;
    longint best = 0;
    exp_q.delete();
    npos = (smp.size() - k) / s + 1;
    for (int i = 0; i < npos; i++) begin
      a = 0;
      for (int t = 0; t < k; t++) a += longint'(wgt[u][t]) * longint'(smp[i*s+t]);
      a = a >>> uF[u];
      a += longint'(bia[u]);
      if (a > 32767) a = 32767;
      else if (a < -32768) a = -32768;
      if (uR[u] != 0 && a < 0) a = 0;
      if (i % p == 0 || a > best) best = a;
      if (i % p == p - 1) exp_q.push_back(int'(best));
    end
  endtask

  task automatic gen_samples(input int u, input int nout, input int lo, input int hi);
    int ns = uK[u] + (nout * uP[u] - 1) * uS[u];
    smp.delete();
    for (int i = 0; i < ns; i++) smp.push_back(int'($urandom_range(0, hi - lo)) + lo);
  endtask

  task automatic gen_weights(input int u, input int lo, input int hi);
    for (int i = 0; i < uK[u]; i++) wgt[u][i] = int'($urandom_range(0, hi - lo)) + lo;
    bia[u] = int'($urandom_range(0, 2000)) - 1000;
  endtask

  task automatic load_w(input int u);
    int i = 0;
    int k = uK[u];
    bit a;
    @(negedge clk);
    en_w[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en_w[u] = 1'b0;
    for (int n = 0; n < 100 && i <= k; n++) begin
      stb[u] = 1'b1;
      data = (i < k) ? 16'(wgt[u][i]) : 16'(bia[u]);
      a = ack_in[u];
      @(posedge clk);
      if (a) i++;
      @(negedge clk);
    end
    stb[u] = 1'b0;
    if (i <= k) to_flag = 1'b1;
  endtask

  // Streams smp into unit u and collects nexp results; fixed_dly>=0 gives a fixed ack delay.
  task automatic drive_run(input int u, input int nexp, input int fixed_dly, input int dly_max);
    int si = 0;
    int cyc = 0;
    int last_acc = 0;
    int hold = 0;
    int dly;
    bit prev = 1'b0;
    bit a;
    bit done = 1'b0;
    logic [15:0] held = '0;
    outq.delete();
    latq.delete();
    bp_bad = 0;
    bp_cnt = 0;
    dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, dly_max));
    @(negedge clk);
    en_c[u] = 1'b1;
    for (int n = 0; n < 4000 && !done; n++) begin
      ack_out[u] = 1'b0;
      if (ostb[u]) begin
        if (!prev) begin
          latq.push_back(cyc - last_acc);
          held = odata[u];
          hold = 0;
        end else if (odata[u] !== held || ack_in[u] !== 1'b0) begin
          bp_bad++;
        end
        prev = 1'b1;
        if (hold >= dly) begin
          outq.push_back(int'($signed(odata[u])));
          ack_out[u] = 1'b1;
          if (outq.size() >= nexp) en_c[u] = 1'b0;
          dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, dly_max));
        end else begin
          hold++;
          bp_cnt++;
        end
      end else begin
        prev = 1'b0;
      end
      if (si < smp.size()) begin
        stb[u] = 1'b1;
        data = 16'(smp[si]);
      end else begin
        stb[u] = 1'b0;
      end
      a = stb[u] & ack_in[u];
      @(posedge clk);
      cyc++;
      if (a) begin
        si++;
        last_acc = cyc;
      end
      @(negedge clk);
      if (outq.size() >= nexp && !busy[u] && si == smp.size()) done = 1'b1;
    end
    stb[u] = 1'b0;
    ack_out[u] = 1'b0;
    en_c[u] = 1'b0;
    if (!done) to_flag = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    for (int u = 0; u < 4; u++) begin
      total += 4;
      if (odata[u] !== 16'h0) begin bad++; $display("FAIL reset_odata u%0d: got %h want 0", u, odata[u]); end
      if (ostb[u] !== 1'b0) begin bad++; $display("FAIL reset_ostb u%0d: got %b want 0", u, ostb[u]); end
      if (ack_in[u] !== 1'b0) begin bad++; $display("FAIL reset_ack_in u%0d: got %b want 0", u, ack_in[u]); end
      if (busy[u] !== 1'b0) begin bad++; $display("FAIL reset_busy u%0d: got %b want 0", u, busy[u]); end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int o0;
    to_flag = 1'b0;
    wgt[0][0] = 1; wgt[0][1] = 2; wgt[0][2] = 3; bia[0] = 10;
    load_w(0);
    smp = '{1, 2, 3, 4};
    drive_run(0, 1, 0, 0);
    o0 = (outq.size() > 0) ? outq[0] : -99999;
    total += 3;
    if (to_flag !== 1'b0) begin bad++; $display("FAIL basic_timeout: got %b want 0", to_flag); end
    if (o0 !== 30) begin bad++; $display("FAIL basic_out: got %0d want 30", o0); end
    if (latq.size() !== 1 || latq[0] !== 4) begin bad++; $display("FAIL basic_latency: got %p want 4", latq); end
    repeat (6) @(negedge clk);
    total++;
    if (ostb[0] !== 1'b0 || busy[0] !== 1'b0 || outq.size() !== 1) begin
      bad++; $display("FAIL basic_one_strobe: ostb=%b busy=%b n=%0d want 0 0 1", ostb[0], busy[0], outq.size());
    end
  endtask

  task automatic test_saturation;
    int o0;
    for (int pass = 0; pass < 2; pass++) begin
      to_flag = 1'b0;
      for (int i = 0; i < 3; i++) wgt[0][i] = (pass == 0) ? 32767 : -32768;
      bia[0] = 0;
      load_w(0);
      smp = '{32767, 32767, 32767, 32767};
      drive_run(0, 1, 0, 0);
      o0 = (outq.size() > 0) ? outq[0] : -99999;
      total++;
      if (o0 !== ((pass == 0) ? 32767 : -32768) || to_flag !== 1'b0) begin
        bad++; $display("FAIL saturation_%0d: got %0d want %0d", pass, o0, (pass == 0) ? 32767 : -32768);
      end
    end
  endtask

  task automatic test_relu;
    int o0;
    for (int u = 0; u < 2; u++) begin
      to_flag = 1'b0;
      wgt[u][0] = -1; wgt[u][1] = 0; wgt[u][2] = 0; bia[u] = 0;
      load_w(u);
      smp = '{5, 6, 7, 8};
      drive_run(u, 1, 1, 0);
      o0 = (outq.size() > 0) ? outq[0] : -99999;
      total++;
      if (o0 !== ((u == 0) ? -5 : 0) || to_flag !== 1'b0) begin
        bad++; $display("FAIL relu_%0d: got %0d want %0d", u, o0, (u == 0) ? -5 : 0);
      end
    end
  endtask

  task automatic test_stride;
    int want[3] = '{6, 12, 18};
    to_flag = 1'b0;
    wgt[2][0] = 1; wgt[2][1] = 1; wgt[2][2] = 1; bia[2] = 0;
    load_w(2);
    smp = '{1, 2, 3, 4, 5, 6, 7};
    drive_run(2, 3, 0, 0);
    total++;
    if (outq.size() !== 3 || to_flag !== 1'b0) begin bad++; $display("FAIL stride_count: got %0d want 3", outq.size()); end
    for (int i = 0; i < 3 && i < outq.size(); i++) begin
      total++;
      if (outq[i] !== want[i]) begin bad++; $display("FAIL stride_out%0d: got %0d want %0d", i, outq[i], want[i]); end
    end
    for (int i = 0; i < latq.size(); i++) begin
      total++;
      if (latq[i] !== 4) begin bad++; $display("FAIL stride_latency%0d: got %0d want 4", i, latq[i]); end
    end
  endtask

  task automatic test_backpressure;
    to_flag = 1'b0;
    gen_weights(0, -300, 300);
    load_w(0);
    gen_samples(0, 3, -500, 500);
    model(0);
    drive_run(0, 3, 10, 0);
    total += 3;
    if (bp_bad !== 0) begin bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bp_bad); end
    if (bp_cnt !== 30) begin bad++; $display("FAIL bp_hold: got %0d held cycles want 30", bp_cnt); end
    if (outq.size() !== exp_q.size() || to_flag !== 1'b0) begin
      bad++; $display("FAIL bp_count: got %0d want %0d", outq.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < outq.size(); i++) begin
      total++;
      if (outq[i] !== exp_q[i]) begin bad++; $display("FAIL bp_out%0d: got %0d want %0d", i, outq[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_mac;
    int si = 0;
    int o0;
    bit a;
    to_flag = 1'b0;
    wgt[0][0] = 1; wgt[0][1] = 2; wgt[0][2] = 3; bia[0] = 10;
    load_w(0);
    @(negedge clk);
    en_c[0] = 1'b1;
    for (int n = 0; n < 20 && si < 3; n++) begin
      stb[0] = 1'b1;
      data = 16'(si + 1);
      a = ack_in[0];
      @(posedge clk);
      if (a) si++;
      @(negedge clk);
    end
    stb[0] = 1'b0;
    total += 2;
    if (busy[0] !== 1'b1) begin bad++; $display("FAIL mac_busy: got %b want 1", busy[0]); end
    if (ack_in[0] !== 1'b0) begin bad++; $display("FAIL mac_ack_in: got %b want 0", ack_in[0]); end
    rst = 1'b1;
    #1;
    total += 3;
    if (ostb[0] !== 1'b0) begin bad++; $display("FAIL rstmac_ostb: got %b want 0", ostb[0]); end
    if (ack_in[0] !== 1'b0) begin bad++; $display("FAIL rstmac_ack_in: got %b want 0", ack_in[0]); end
    if (busy[0] !== 1'b0) begin bad++; $display("FAIL rstmac_busy: got %b want 0", busy[0]); end
    @(negedge clk);
    rst = 1'b0;
    en_c[0] = 1'b0;
    for (int i = 0; i < 3; i++) wgt[0][i] = 0;
    bia[0] = 0;
    gen_samples(0, 1, -1000, 1000);
    drive_run(0, 1, 0, 0);
    o0 = (outq.size() > 0) ? outq[0] : -99999;
    total++;
    if (o0 !== 0 || to_flag !== 1'b0) begin bad++; $display("FAIL rstmac_noreload: got %0d want 0", o0); end
  endtask

  task automatic test_random;
    int units[3] = '{0, 1, 3};
    int u;
    for (int it = 0; it < 9; it++) begin
      u = units[it % 3];
      to_flag = 1'b0;
      if (it >= 6) gen_weights(u, -32768, 32767);
      else gen_weights(u, -400, 400);
      load_w(u);
      if (it >= 6) gen_samples(u, 3, -32768, 32767);
      else gen_samples(u, 3, -800, 800);
      model(u);
      drive_run(u, exp_q.size(), -1, 3);
      total++;
      if (outq.size() !== exp_q.size() || to_flag !== 1'b0) begin
        bad++; $display("FAIL rand%0d_count u%0d: got %0d want %0d", it, u, outq.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < outq.size(); i++) begin
        total++;
        if (outq[i] !== exp_q[i]) begin
          bad++; $display("FAIL rand%0d_out%0d u%0d: got %0d want %0d", it, i, u, outq[i], exp_q[i]);
        end
      end
      for (int i = 0; i < latq.size(); i++) begin
        total++;
        if (latq[i] !== uK[u] + 1) begin
          bad++; $display("FAIL rand%0d_lat%0d u%0d: got %0d want %0d", it, i, u, latq[i], uK[u] + 1);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    to_flag = 1'b0;
    gen_weights(2, -1000, 1000);
    load_w(2);
    gen_samples(2, 8, -2000, 2000);
    model(2);
    drive_run(2, 8, 0, 0);
    total++;
    if (outq.size() !== 8 || to_flag !== 1'b0) begin bad++; $display("FAIL b2b_count: got %0d want 8", outq.size()); end
    for (int i = 0; i < exp_q.size() && i < outq.size(); i++) begin
      total++;
      if (outq[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_out%0d: got %0d want %0d", i, outq[i], exp_q[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    data = '0;
    en_w = '0;
    en_c = '0;
    stb = '0;
    ack_out = '0;
    repeat (2) @(negedge clk);
    test_reset;
    test_basic;
    test_saturation;
    test_relu;
    test_stride;
    test_backpressure;
    test_reset_mid_mac;
    test_random;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
